dmem_obi_arbiter: RTL

Two-host to one-device OBI arbiter that shares the 64-bit data-memory port between the memory stage (host 0) and a secondary requester (host 1, e.g. debug/DMA). It performs round-robin arbitration with address-phase locking and tracks outstanding transactions in an ID FIFO so each response reaches the host that issued it. It sits between the requesters' OBI host drivers and the external dmem interface.

---
 rtl/dmem_obi_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_obi_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_obi_arbiter
//
// Shares the single 64-bit data-memory OBI port between two requesters:
// host 0 (memory stage) and host 1 (secondary requester such as debug/DMA).
// Arbitration is round-robin. Once a request has been presented to the
// device without a grant, the selection is locked to that host until the
// grant arrives, so the address phase stays stable. Every accepted
// transfer pushes the issuing host ID into a small FIFO. Each device
// response pops that FIFO, which steers rvalid back to the right host.
//
// Ports
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   hN_req_i / hN_gnt_o              host request / grant (N = 0, 1)
//   hN_addr_i, hN_we_i, hN_be_i,
//   hN_wdata_i                       host address-phase fields
//   hN_rvalid_o                      response valid routed to host N
//   h_rdata_o                        read data shared by both hosts
//   dmem_req_o / dmem_gnt_i          device request / grant
//   dmem_addr_o, dmem_we_o,
//   dmem_be_o, dmem_wdata_o          muxed address-phase fields
//   dmem_rvalid_i, dmem_rdata_i      device response
//   outst_cnt_o                      granted-but-unanswered transaction count
//   err_o                            sticky: response seen with nothing pending
// ---------------------------------------------------------------------------
module dmem_obi_arbiter #(
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         h0_req_i,
   output logic                         h0_gnt_o,
   input  logic [63:0]                  h0_addr_i,
   input  logic                         h0_we_i,
   input  logic [7:0]                   h0_be_i,
   input  logic [63:0]                  h0_wdata_i,
   output logic                         h0_rvalid_o,
   input  logic                         h1_req_i,
   output logic                         h1_gnt_o,
   input  logic [63:0]                  h1_addr_i,
   input  logic                         h1_we_i,
   input  logic [7:0]                   h1_be_i,
   input  logic [63:0]                  h1_wdata_i,
   output logic                         h1_rvalid_o,
   output logic [63:0]                  h_rdata_o,
   output logic                         dmem_req_o,
   input  logic                         dmem_gnt_i,
   output logic [63:0]                  dmem_addr_o,
   output logic                         dmem_we_o,
   output logic [7:0]                   dmem_be_o,
   output logic [63:0]                  dmem_wdata_o,
   input  logic                         dmem_rvalid_i,
   input  logic [63:0]                  dmem_rdata_i,
   output logic [$clog2(MAX_OUTST):0]   outst_cnt_o,
   output logic                         err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
   localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   typedef enum logic {
      IDLE,
      LOCKED
   } arbState_e;

   arbState_e          state_q;
   logic               lockHost_q;
   logic               rrPtr_q;
   logic               fifoMem_q [MAX_OUTST];
   logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q;

   logic               sel;
   logic               selReq;
   logic               fieldSel;
   logic               full;
   logic               fifoEmpty;
   logic               reqOut;
   logic               accept;
   logic               pop;
   logic               head;

   // Pointers wrap modulo MAX_OUTST; this also keeps a depth-1 FIFO at slot 0.
   function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUTST - 1)) begin
         ptrInc = '0;
      end else begin
         ptrInc = p + 1'b1;
      end
   endfunction

   // Selection: a locked address phase always wins. Otherwise a lone
   // requester is taken, and the round-robin pointer breaks ties.
   always_comb begin
      sel = 1'b0;
      if (state_q == LOCKED) begin
         sel = lockHost_q;
      end else if (h0_req_i && h1_req_i) begin
         sel = rrPtr_q;
      end else if (h1_req_i) begin
         sel = 1'b1;
      end
   end

   // Request and response paths are purely combinational. Reset gates the
   // handshake outputs so they drop the moment reset is asserted, even while
   // a host keeps its request high. A full FIFO blocks the request even if a
   // pop frees a slot in the same cycle; the slot is usable next cycle.
   always_comb begin
      selReq    = sel ? h1_req_i : h0_req_i;
      full      = (cnt_q == CNT_W'(MAX_OUTST));
      fifoEmpty = (cnt_q == '0);
      reqOut    = selReq & ~full & ~rst_i;
      accept    = reqOut & dmem_gnt_i;
      pop       = dmem_rvalid_i & ~fifoEmpty & ~rst_i;
      head      = fifoMem_q[rdPtr_q];
      fieldSel  = selReq & sel;
   end

   assign dmem_req_o   = reqOut;
   assign dmem_addr_o  = fieldSel ? h1_addr_i  : h0_addr_i;
   assign dmem_we_o    = fieldSel ? h1_we_i    : h0_we_i;
   assign dmem_be_o    = fieldSel ? h1_be_i    : h0_be_i;
   assign dmem_wdata_o = fieldSel ? h1_wdata_i : h0_wdata_i;

   assign h0_gnt_o     = accept & ~sel;
   assign h1_gnt_o     = accept &  sel;
   assign h0_rvalid_o  = pop & ~head;
   assign h1_rvalid_o  = pop &  head;
   assign h_rdata_o    = dmem_rdata_i;
   assign outst_cnt_o  = cnt_q;
   assign err_o        = err_q;

   // FIFO bookkeeping. A push and a pop in the same cycle leave the count
   // unchanged while both pointers advance.
   always_comb begin
      wrPtr_d = accept ? ptrInc(wrPtr_q) : wrPtr_q;
      rdPtr_d = pop    ? ptrInc(rdPtr_q) : rdPtr_q;
      cnt_d   = cnt_q;
      if (accept && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!accept && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Arbitration FSM. The selection locks when the device sees a request
   // but does not grant it. It unlocks on the grant, or if the locked host
   // withdraws its request. A full FIFO keeps the lock because the locked
   // host is still requesting. Every accepted transfer hands priority to
   // the other host.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         lockHost_q <= 1'b0;
         rrPtr_q    <= 1'b0;
      end else begin
         if (accept) begin
            rrPtr_q <= ~sel;
         end
         case (state_q)
            IDLE: begin
               if (reqOut && !dmem_gnt_i) begin
                  state_q    <= LOCKED;
                  lockHost_q <= sel;
               end
            end
            LOCKED: begin
               if (accept || !selReq) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // ID FIFO storage, pointers, and the sticky error for a response
   // that arrives while no transaction is outstanding.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(MAX_OUTST); i++) begin
            fifoMem_q[i] <= 1'b0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            fifoMem_q[wrPtr_q] <= sel;
         end
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         cnt_q   <= cnt_d;
         if (dmem_rvalid_i && fifoEmpty) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule
